// File: rtl/operand_stage_if.sv
// Decode, register-file, forwarding and execute signals of the operand stage.
// master = operand_stage, slave = surrounding pipeline.
interface operand_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  id_valid, id_ready;
  logic [ADDR_WIDTH-1:0] id_rs1, id_rs2, id_rd;
  logic                  id_use_rs1, id_use_rs2, id_is_load;
  logic [DATA_WIDTH-1:0] id_imm, id_pc;
  logic [ADDR_WIDTH-1:0] rf_read_address_1, rf_read_address_2;
  logic [DATA_WIDTH-1:0] rf_data_1, rf_data_2;
  logic                  fwd_ex_valid, fwd_ex_is_load;
  logic [ADDR_WIDTH-1:0] fwd_ex_rd;
  logic [DATA_WIDTH-1:0] fwd_ex_data;
  logic                  fwd_mem_valid;
  logic [ADDR_WIDTH-1:0] fwd_mem_rd;
  logic [DATA_WIDTH-1:0] fwd_mem_data;
  logic                  wb_write_enable;
  logic [ADDR_WIDTH-1:0] wb_write_address;
  logic [DATA_WIDTH-1:0] wb_write_data;
  logic                  ex_valid, ex_ready;
  logic [DATA_WIDTH-1:0] ex_op1, ex_op2, ex_imm, ex_pc;
  logic [ADDR_WIDTH-1:0] ex_rd;
  logic                  ex_is_load;

  modport master (
    input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_is_load, id_imm, id_pc,
    output id_ready, rf_read_address_1, rf_read_address_2,
    input  rf_data_1, rf_data_2,
    input  fwd_ex_valid, fwd_ex_is_load, fwd_ex_rd, fwd_ex_data,
    input  fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
    input  wb_write_enable, wb_write_address, wb_write_data,
    output ex_valid, ex_op1, ex_op2, ex_imm, ex_pc, ex_rd, ex_is_load,
    input  ex_ready
  );

  modport slave (
    output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_is_load, id_imm, id_pc,
    input  id_ready, rf_read_address_1, rf_read_address_2,
    output rf_data_1, rf_data_2,
    output fwd_ex_valid, fwd_ex_is_load, fwd_ex_rd, fwd_ex_data,
    output fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
    output wb_write_enable, wb_write_address, wb_write_data,
    input  ex_valid, ex_op1, ex_op2, ex_imm, ex_pc, ex_rd, ex_is_load,
    output ex_ready
  );
endinterface

// File: rtl/operand_stage.sv
// Operand stage: register-file read slot, forwarding/bypass select, load-use stall, EX output register.
// Define OPERAND_FWD_EN to enable EX/MEM forwarding; otherwise EX/MEM producers stall.
module operand_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  operand_stage_if.master io
);
  localparam int NOPS = 2;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef struct packed { addr_t rd; logic is_load; data_t imm; data_t pc; } ctl_t;
  typedef struct packed { data_t op2; data_t op1; ctl_t ctl; } ex_t;

  logic                             r_valid_q;
  logic [NOPS-1:0][ADDR_WIDTH-1:0]  r_rs_q, id_rs, rf_addr;
  logic [NOPS-1:0]                  r_use_q, haz;
  ctl_t                             r_ctl_q;
  logic [NOPS-1:0][DATA_WIDTH-1:0]  rf_data, opnd;
  logic                             ex_valid_q;
  ex_t                              ex_q;
  logic                             accept, advance, hazard, id_ready;

  assign id_rs   = {io.id_rs2, io.id_rs1};
  assign rf_data = {io.rf_data_2, io.rf_data_1};
  assign hazard  = r_valid_q & (|haz);
  assign advance = r_valid_q & ~hazard & (~ex_valid_q | io.ex_ready);
  // Reset gating keeps id_ready, and with it the read addresses, at 0 during reset.
  assign id_ready = reset & ~flush & (~r_valid_q | advance);
  assign accept   = io.id_valid & id_ready;

  for (genvar g = 0; g < NOPS; g++) begin : g_op
    logic  ex_hit, mem_hit, wb_hit, byp_d, byp_q;
    data_t byp_val_q, sel;

    assign rf_addr[g] = accept ? id_rs[g] : r_rs_q[g];
    assign ex_hit  = io.fwd_ex_valid    & (io.fwd_ex_rd == r_rs_q[g])        & (r_rs_q[g] != '0);
    assign mem_hit = io.fwd_mem_valid   & (io.fwd_mem_rd == r_rs_q[g])       & (r_rs_q[g] != '0);
    assign wb_hit  = io.wb_write_enable & (io.wb_write_address == r_rs_q[g]) & (r_rs_q[g] != '0);
    // The file returns pre-write data when read and write share an edge; capture the write.
    assign byp_d   = io.wb_write_enable & (io.wb_write_address == rf_addr[g]) & (rf_addr[g] != '0);

`ifdef OPERAND_FWD_EN
    assign haz[g] = r_use_q[g] & ex_hit & io.fwd_ex_is_load;
`else
    assign haz[g] = r_use_q[g] & (ex_hit | mem_hit);
`endif

    always_comb begin
      sel = rf_data[g];
      if (r_rs_q[g] == '0)                     sel = '0;
`ifdef OPERAND_FWD_EN
      else if (ex_hit && !io.fwd_ex_is_load)   sel = io.fwd_ex_data;
      else if (mem_hit)                        sel = io.fwd_mem_data;
`endif
      else if (wb_hit)                         sel = io.wb_write_data;
      else if (byp_q)                          sel = byp_val_q;
    end
    assign opnd[g] = sel;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        byp_q     <= 1'b0;
        byp_val_q <= '0;
      end else begin
        byp_q <= byp_d;
        if (byp_d) byp_val_q <= io.wb_write_data;
      end
    end
  end

`ifndef OPERAND_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{io.fwd_ex_data, io.fwd_mem_data, io.fwd_ex_is_load};
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid_q <= 1'b0;
      r_rs_q    <= '0;
      r_use_q   <= '0;
      r_ctl_q   <= '0;
    end else if (flush) begin
      r_valid_q <= 1'b0;
    end else if (accept) begin
      r_valid_q <= 1'b1;
      r_rs_q    <= id_rs;
      r_use_q   <= {io.id_use_rs2, io.id_use_rs1};
      r_ctl_q   <= '{rd: io.id_rd, is_load: io.id_is_load, imm: io.id_imm, pc: io.id_pc};
    end else if (advance) begin
      r_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (advance) begin
      ex_valid_q <= 1'b1;
      ex_q       <= '{op2: opnd[1], op1: opnd[0], ctl: r_ctl_q};
    end else if (io.ex_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign io.id_ready          = id_ready;
  assign io.rf_read_address_1 = rf_addr[0];
  assign io.rf_read_address_2 = rf_addr[1];
  assign io.ex_valid          = ex_valid_q;
  assign io.ex_op1            = ex_q.op1;
  assign io.ex_op2            = ex_q.op2;
  assign io.ex_imm            = ex_q.ctl.imm;
  assign io.ex_pc             = ex_q.ctl.pc;
  assign io.ex_rd             = ex_q.ctl.rd;
  assign io.ex_is_load        = ex_q.ctl.is_load;
endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage with a registered-read register file model (reset contents = index).
module tb_operand_stage;
  logic clock, reset, flush;
  int   nchk = 0, npass = 0, nfail = 0;

  operand_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
  operand_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock(clock), .reset(reset), .flush(flush), .io(bus.master));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file: read data registered, read returns pre-write contents on a shared edge.
  logic [31:0] mem [32];
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
    end else if (bus.wb_write_enable && bus.wb_write_address != 5'd0) begin
      mem[bus.wb_write_address] <= bus.wb_write_data;
    end
    bus.rf_data_1 <= mem[bus.rf_read_address_1];
    bus.rf_data_2 <= mem[bus.rf_read_address_2];
  end

  task automatic step(int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic set_id(bit v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                        bit u1, bit u2, bit ld, logic [31:0] imm, logic [31:0] pc);
    bus.id_valid = v;   bus.id_rs1 = rs1;    bus.id_rs2 = rs2;    bus.id_rd = rd;
    bus.id_use_rs1 = u1; bus.id_use_rs2 = u2; bus.id_is_load = ld;
    bus.id_imm = imm;   bus.id_pc = pc;
  endtask

  task automatic set_ex(bit v, logic [4:0] rd, bit ld, logic [31:0] d);
    bus.fwd_ex_valid = v; bus.fwd_ex_rd = rd; bus.fwd_ex_is_load = ld; bus.fwd_ex_data = d;
  endtask

  task automatic set_mem(bit v, logic [4:0] rd, logic [31:0] d);
    bus.fwd_mem_valid = v; bus.fwd_mem_rd = rd; bus.fwd_mem_data = d;
  endtask

  task automatic set_wb(bit v, logic [4:0] a, logic [31:0] d);
    bus.wb_write_enable = v; bus.wb_write_address = a; bus.wb_write_data = d;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; bus.ex_ready = 1'b1;
    set_ex(0, 0, 0, 0); set_mem(0, 0, 0); set_wb(0, 0, 0);
    set_id(1, 5'd5, 5'd7, 5'd1, 1, 1, 1, 32'h10, 32'h100);
    step(3);
    // Reset: outputs quiet even with id_valid asserted.
    chk("rst_id_ready", 32'(bus.id_ready), 0);
    chk("rst_rf_addr1", 32'(bus.rf_read_address_1), 0);
    chk("rst_ex_valid", 32'(bus.ex_valid), 0);
    chk("rst_ex_op1",   bus.ex_op1, 0);
    reset = 1'b1;
    #1 chk("first_id_ready", 32'(bus.id_ready), 1);
    step();                                    // accept x5/x7
    bus.id_valid = 1'b0;
    chk("lat_ex_valid0", 32'(bus.ex_valid), 0);
    step();
    chk("basic_ex_valid", 32'(bus.ex_valid), 1);
    chk("basic_op1", bus.ex_op1, 32'd5);
    chk("basic_op2", bus.ex_op2, 32'd7);
    chk("basic_pc",  bus.ex_pc, 32'h100);
    chk("basic_load", 32'(bus.ex_is_load), 1);
    step();
    chk("bubble_ex_valid", 32'(bus.ex_valid), 0);

    // EX forwarding of x3.
    set_id(1, 5'd3, 5'd0, 5'd2, 1, 0, 0, 32'h20, 32'h104);
    set_ex(1, 5'd3, 0, 32'h1234);
    step();
    bus.id_valid = 1'b0;
`ifdef OPERAND_FWD_EN
    step();
`else
    chk("exdep_id_ready", 32'(bus.id_ready), 0);
    set_ex(0, 0, 0, 0); set_mem(1, 5'd3, 32'h1234);
    step();
    chk("exdep_bubble", 32'(bus.ex_valid), 0);
    set_mem(0, 0, 0); set_wb(1, 5'd3, 32'h1234);
    step();
    set_wb(0, 0, 0);
`endif
    chk("fwd_ex_valid", 32'(bus.ex_valid), 1);
    chk("fwd_ex_op1", bus.ex_op1, 32'h1234);
    set_ex(0, 0, 0, 0);
    step();

    // Load-use on rs2 = x4.
    set_id(1, 5'd1, 5'd4, 5'd6, 1, 1, 0, 32'h30, 32'h108);
    set_ex(1, 5'd4, 1, 32'hDEAD);
    step();
    bus.id_valid = 1'b0;
    chk("ldu_id_ready", 32'(bus.id_ready), 0);
    step();
    chk("ldu_bubble", 32'(bus.ex_valid), 0);
    set_ex(0, 0, 0, 0); set_mem(1, 5'd4, 32'hCAFE);
`ifdef OPERAND_FWD_EN
    #1 chk("ldu_resume_ready", 32'(bus.id_ready), 1);
    step();
`else
    step();
    chk("ldu_mem_bubble", 32'(bus.ex_valid), 0);
    set_mem(0, 0, 0); set_wb(1, 5'd4, 32'hCAFE);
    step();
    set_wb(0, 0, 0);
`endif
    chk("ldu_ex_valid", 32'(bus.ex_valid), 1);
    chk("ldu_op2", bus.ex_op2, 32'hCAFE);
    chk("ldu_op1", bus.ex_op1, 32'd1);
    set_mem(0, 0, 0);
    step();

    // Same-edge WB write and read of x9.
    set_id(1, 5'd9, 5'd0, 5'd2, 1, 0, 0, 32'h40, 32'h10C);
    set_wb(1, 5'd9, 32'hBEEF);
    step();
    bus.id_valid = 1'b0; set_wb(0, 0, 0);
    step();
    chk("wbbyp_op1", bus.ex_op1, 32'hBEEF);
    step();

    // Back-pressure with a WB update to the held instruction's rs.
    bus.ex_ready = 1'b0;
    set_id(1, 5'd10, 5'd11, 5'd1, 1, 1, 0, 32'h50, 32'h110);
    step();
    set_id(1, 5'd12, 5'd0, 5'd13, 1, 0, 0, 32'h60, 32'h114);
    step();
    bus.id_valid = 1'b0;
    chk("bp_ex_valid", 32'(bus.ex_valid), 1);
    chk("bp_op1", bus.ex_op1, 32'd10);
    chk("bp_op2", bus.ex_op2, 32'd11);
    chk("bp_id_ready", 32'(bus.id_ready), 0);
    set_wb(1, 5'd12, 32'h5A5A);
    step();
    set_wb(0, 0, 0);
    chk("bp_hold1_op1", bus.ex_op1, 32'd10);
    step(2);
    chk("bp_hold3_op1", bus.ex_op1, 32'd10);
    chk("bp_hold3_pc", bus.ex_pc, 32'h110);
    chk("bp_hold3_id_ready", 32'(bus.id_ready), 0);
    bus.ex_ready = 1'b1;
    step();
    chk("bp_release_valid", 32'(bus.ex_valid), 1);
    chk("bp_release_op1", bus.ex_op1, 32'h5A5A);
    chk("bp_release_rd", 32'(bus.ex_rd), 32'd13);

    // Flush with R and EX both occupied.
    bus.ex_ready = 1'b0;
    set_id(1, 5'd2, 5'd3, 5'd5, 1, 1, 0, 32'h70, 32'h118);
    step();
    bus.id_valid = 1'b0; flush = 1'b1;
    #1 chk("flush_id_ready", 32'(bus.id_ready), 0);
    step();
    chk("flush_ex_valid", 32'(bus.ex_valid), 0);
    flush = 1'b0; bus.ex_ready = 1'b1;
    #1 chk("postflush_id_ready", 32'(bus.id_ready), 1);
    step();
    chk("postflush_ex_valid", 32'(bus.ex_valid), 0);

    // x0 source ignores an EX producer writing rd=0.
    set_id(1, 5'd0, 5'd5, 5'd8, 1, 1, 0, 32'h80, 32'h11C);
    set_ex(1, 5'd0, 0, 32'hFFFF);
    step();
    bus.id_valid = 1'b0;
    step();
    chk("x0_ex_valid", 32'(bus.ex_valid), 1);
    chk("x0_op1", bus.ex_op1, 32'd0);
    chk("x0_op2", bus.ex_op2, 32'd5);
    set_ex(0, 0, 0, 0);
    step();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/operand_stage.md
# operand_stage

- Sits between the decode logic and the execute stage of the RISC-V pipeline.
- Issues read addresses to the register file and holds each instruction one cycle while the file's registered read data arrives.
- Resolves operands by forwarding from EX, MEM and WB, detects load-use hazards, and presents a valid/ready-handshaked operand bundle to EX.
- Throughput is one instruction per cycle when there is no hazard.

## Interface
- `DATA_WIDTH`, default 32: operand, immediate and PC width.
- `ADDR_WIDTH`, default 5: register index width.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `flush` in 1: drops every instruction held in this block.
- `id_valid` in 1, `id_ready` out 1: decode handshake.
- `id_rs1`, `id_rs2`, `id_rd` in ADDR_WIDTH; `id_use_rs1`, `id_use_rs2`, `id_is_load` in 1; `id_imm`, `id_pc` in DATA_WIDTH.
- `rf_read_address_1`, `rf_read_address_2` out ADDR_WIDTH: to the register file. Its data is registered, so it appears the cycle after the edge.
- `rf_data_1`, `rf_data_2` in DATA_WIDTH: register file outputs.
- `fwd_ex_valid`, `fwd_ex_is_load` in 1; `fwd_ex_rd` in ADDR_WIDTH; `fwd_ex_data` in DATA_WIDTH: the instruction currently in EX.
- `fwd_mem_valid` in 1; `fwd_mem_rd` in ADDR_WIDTH; `fwd_mem_data` in DATA_WIDTH: MEM result, including load data.
- `wb_write_enable` in 1; `wb_write_address` in ADDR_WIDTH; `wb_write_data` in DATA_WIDTH: the same signals that drive the register-file write port.
- `ex_valid` out 1, `ex_ready` in 1: execute handshake.
- `ex_op1`, `ex_op2`, `ex_imm`, `ex_pc` out DATA_WIDTH; `ex_rd` out ADDR_WIDTH; `ex_is_load` out 1.

## Operation
**Read slot R**
- Holds one instruction: its fields, `r_valid`, and per-operand bypass registers.
- `accept` = `id_valid & id_ready`.
- `rf_read_address_n` = `id_rsn` when `accept`, otherwise R's `rsn`. While R holds, the file is re-read every edge, so `rf_data` stays current.

**WB bypass latch**
- The register file returns pre-write data when a write and a read hit the same edge.
- On every edge where the file samples address `a`, and `wb_write_enable & wb_write_address==a & a!=0`, latch `wb_write_data` and set the operand's bypass flag.
- On any other edge, clear the flag.

**Operand select** (per operand, in R, evaluated as a priority chain)
1. rs==0 → 0.
2. EX match (`fwd_ex_valid`, rd==rs, not load) → `fwd_ex_data`.
3. MEM match → `fwd_mem_data`.
4. Current WB match → `wb_write_data`.
5. Bypass flag set → latched bypass value.
6. Otherwise → `rf_data`.

Matches never apply when rd==0.

**Hazard and flow control**
- `hazard` = `r_valid` & (`id_use_rsn` & `fwd_ex_valid` & `fwd_ex_is_load` & `fwd_ex_rd==rsn` & rsn!=0) for either operand.
- `advance` = `r_valid & !hazard & (!ex_valid | ex_ready)`.
- `id_ready` = `!flush & (!r_valid | advance)`.

**Output register**
- On `advance`, load the `ex_*` fields and set `ex_valid=1`.
- Otherwise, if `ex_ready`, clear `ex_valid` (bubble).
- `ex_*` data hold when `ex_valid` is 0.

**Flush**
- At the next edge: `r_valid=0`, `ex_valid=0`, nothing accepted. Flush overrides `id_valid` and `advance`.

**Reset**
- `r_valid`, `ex_valid`, all `ex_*`, bypass flags and `rf_read_address_*` are 0.

## Timing
- Instruction accepted at edge N → register-file data valid in cycle N+1 → `ex_valid` high after edge N+1 (latency 1 cycle, throughput 1/cycle).
- Load-use:
  - Load in EX with a dependent instruction in R → exactly one bubble.
  - The load moves to MEM and R advances the next cycle using `fwd_mem_data`.
- EX back-pressure (`ex_ready=0` with `ex_valid=1`) → R holds, `id_ready=0`, and R's operands keep tracking forwarding and WB updates each cycle.
- Reset deasserted mid-stream: the first accept can occur at the first edge with reset high.

## Configuration
- `OPERAND_FWD_EN` defined:
  - EX and MEM forwarding as above.
  - Only a load in EX causes a stall.
- Not defined:
  - The EX and MEM sources are removed.
  - `hazard` is raised whenever a used rs matches a valid, nonzero EX or MEM rd, whether or not it is a load.
  - The WB path and the bypass latch remain in both builds.

## Test plan
- **Reset:** reset=0 → all outputs 0. After release, accept x5/x7 (register file reset contents = index) → `ex_op1`=5, `ex_op2`=7, `ex_valid` high one edge after accept.
- **EX forwarding:** `add x3` in EX with `fwd_ex_data`=0x1234 while R reads x3 → `ex_op1`=0x1234. Without `OPERAND_FWD_EN` → one bubble per producer stage, then the same value.
- **Load-use:** load x4 in EX, dependent instruction in R → `ex_valid`=0 for one cycle, `id_ready`=0. Next cycle, `fwd_mem_data`=0xCAFE → `ex_op2`=0xCAFE.
- **Same-edge write/read:** WB writes x9=0xBEEF on the accept edge → `ex_op1`=0xBEEF, not the stale 9.
- **Back-pressure:** `ex_ready`=0 for 3 cycles → `ex_*` stable, `id_ready`=0. A WB write to R's rs during the stall is reflected in the later output.
- **Flush/x0:**
  - `flush` with R and EX occupied → both valids 0 next edge.
  - rs1=0 with `fwd_ex_rd`=0, `fwd_ex_data`=0xFFFF → `ex_op1`=0.
